// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and CPU control flags
// shared between the program loader and whoever feeds / observes it.
interface prog_loader_if #(
    parameter int D = 10
);
    logic         load;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [8:0]   wr_data;
    logic         start;
    logic         done;
    logic         error;

    modport master (
        output load, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, start, done, error
    );

    modport slave (
        input  load, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, start, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (2-byte header with the word count,
// then two bytes per 9-bit instruction) and writes the instructions into
// instruction memory from address 0 upward, holding the CPU in reset meanwhile.
// Optional feature macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match all header and instruction bytes.
// D is limited to 31 so the word-count bound fits in 32 bits.
module prog_loader #(
    parameter int D = 10
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << D;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, INS_LO, INS_HI, CSUM, FIN, ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, INS_LO, INS_HI, FIN, ERR
    } state_t;
`endif

    state_t       state_q, state_d;
    logic [7:0]   hdrLo_q, hdrLo_d;
    logic [7:0]   insLo_q, insLo_d;
    logic [D:0]   count_q, count_d;
    logic [D:0]   index_q, index_d;
    logic         wrEn_q, wrEn_d;
    logic [D-1:0] wrAddr_q, wrAddr_d;
    logic [8:0]   wrData_q, wrData_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]   csum_q, csum_d;
`endif

    logic         inReady;
    logic         accept;
    logic [31:0]  hdrCount;

    assign inReady  = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                      (state_q == INS_LO) || (state_q == INS_HI)
`ifdef PROG_LOADER_CHECKSUM_EN
                      || (state_q == CSUM)
`endif
                      ;
    assign accept   = bus.in_valid && inReady;
    assign hdrCount = {22'd0, bus.in_data[1:0], hdrLo_q};

    assign bus.in_ready = inReady;
    assign bus.start    = (state_q != IDLE) && (state_q != FIN) && (state_q != ERR);
    assign bus.done     = (state_q == FIN);
    assign bus.error    = (state_q == ERR);
    assign bus.wr_en    = wrEn_q;
    assign bus.wr_addr  = wrAddr_q;
    assign bus.wr_data  = wrData_q;

    // State and datapath registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hdrLo_q  <= '0;
            insLo_q  <= '0;
            count_q  <= '0;
            index_q  <= '0;
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrData_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hdrLo_q  <= hdrLo_d;
            insLo_q  <= insLo_d;
            count_q  <= count_d;
            index_q  <= index_d;
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrData_q <= wrData_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Next-state logic: parse one byte per accepted cycle and schedule writes.
    always_comb begin
        state_d  = state_q;
        hdrLo_d  = hdrLo_q;
        insLo_d  = insLo_q;
        count_d  = count_q;
        index_d  = index_q;
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        if (accept && (state_q != CSUM)) begin
            csum_d = csum_q ^ bus.in_data;
        end
`endif
        case (state_q)
            IDLE, ERR: begin
                if (bus.load) begin
                    state_d = HDR_LO;
                    index_d = '0;
                    count_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            HDR_LO: begin
                if (accept) begin
                    hdrLo_d = bus.in_data;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    count_d = hdrCount[D:0];
                    if (bus.in_data[7:2] != 6'd0) begin
                        state_d = ERR;
                    end else if (hdrCount > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (hdrCount == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = FIN;
`endif
                    end else begin
                        state_d = INS_LO;
                    end
                end
            end
            INS_LO: begin
                if (accept) begin
                    insLo_d = bus.in_data;
                    state_d = INS_HI;
                end
            end
            INS_HI: begin
                if (accept) begin
                    if (bus.in_data[7:1] != 7'd0) begin
                        state_d = ERR;
                    end else begin
                        wrEn_d   = 1'b1;
                        wrAddr_d = index_q[D-1:0];
                        wrData_d = {bus.in_data[0], insLo_q};
                        index_d  = index_q + 1'b1;
                        if ((index_q + 1'b1) == count_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = FIN;
`endif
                        end else begin
                            state_d = INS_LO;
                        end
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == csum_q) ? FIN : ERR;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed download scenarios plus
// randomized byte streams compared against a byte-level reference model.
module tb_prog_loader;

    logic clk;
    logic reset;
    int   cyc;
    int   checkCount;
    int   errorCount;

    prog_loader_if #(.D(10)) bus ();

    prog_loader #(.D(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  stream[$];
    logic [18:0] expWrites[$];
    logic        expDone;
    logic        expError;
    int          expConsumed;

    logic [18:0] obsWrites[$];
    int          obsWriteCyc[$];
    int          obsDoneCyc[$];
    logic        obsStartAtDone[$];
    int          presentCyc[$];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to relate write/done timing to accepted bytes.
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampling outputs mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            obsWrites.push_back({bus.wr_addr, bus.wr_data});
            obsWriteCyc.push_back(cyc);
        end
        if (bus.done) begin
            obsDoneCyc.push_back(cyc);
            obsStartAtDone.push_back(bus.start);
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one byte after 'gap' idle cycles, wait (bounded) for acceptance.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            presentCyc.push_back(cyc);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulseLoad();
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic clearObs();
        obsWrites.delete();
        obsWriteCyc.delete();
        obsDoneCyc.delete();
        obsStartAtDone.delete();
        presentCyc.delete();
    endtask

    // Append the XOR of all bytes so far when the checksum build is used.
    task automatic addCsum();
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(x);
`endif
    endtask

    // Reference model: walk the byte stream and derive writes and outcome.
    task automatic refModel();
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] x;
        int cnt;
        int pos;
        expWrites.delete();
        expDone  = 1'b0;
        expError = 1'b0;
        lo  = stream[0];
        hi  = stream[1];
        x   = lo ^ hi;
        pos = 2;
        if (hi[7:2] != 6'd0) begin
            expError    = 1'b1;
            expConsumed = pos;
            return;
        end
        cnt = int'(hi[1:0]) * 256 + int'(lo);
        for (int i = 0; i < cnt; i++) begin
            lo  = stream[pos];
            hi  = stream[pos + 1];
            pos = pos + 2;
            x   = x ^ lo ^ hi;
            if (hi[7:1] != 7'd0) begin
                expError    = 1'b1;
                expConsumed = pos;
                return;
            end
            expWrites.push_back({10'(i), hi[0], lo});
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        pos = pos + 1;
        if (stream[pos - 1] != x) begin
            expError    = 1'b1;
            expConsumed = pos;
            return;
        end
`endif
        expDone     = 1'b1;
        expConsumed = pos;
    endtask

    // Run one download of 'stream' and compare against the model.
    task automatic runStream(input string tag, input int gapMode);
        int gap;
        refModel();
        clearObs();
        pulseLoad();
        checkOutput({tag, " start busy"}, 32'(bus.start), 32'd1);
        checkOutput({tag, " error cleared"}, 32'(bus.error), 32'd0);
        for (int i = 0; i < expConsumed; i++) begin
            if (gapMode == 0)      gap = 0;
            else if (gapMode == 1) gap = ((i % 4) == 1 || (i % 4) == 2) ? 1 : 0;
            else                   gap = $urandom_range(0, 2);
            applyStimulus(stream[i], gap);
        end
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, " write count"}, 32'(obsWrites.size()), 32'(expWrites.size()));
        for (int i = 0; i < expWrites.size(); i++) begin
            if (i < obsWrites.size())
                checkOutput($sformatf("%s write %0d", tag, i), 32'(obsWrites[i]), 32'(expWrites[i]));
        end
        checkOutput({tag, " done count"}, 32'(obsDoneCyc.size()), expDone ? 32'd1 : 32'd0);
        checkOutput({tag, " error"}, 32'(bus.error), 32'(expError));
        checkOutput({tag, " start idle"}, 32'(bus.start), 32'd0);
        checkOutput({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, " wr_en"},    32'(bus.wr_en),    32'd0);
        checkOutput({tag, " start"},    32'(bus.start),    32'd0);
        checkOutput({tag, " done"},     32'(bus.done),     32'd0);
        checkOutput({tag, " error"},    32'(bus.error),    32'd0);
        checkOutput({tag, " wr_addr"},  32'(bus.wr_addr),  32'd0);
        checkOutput({tag, " wr_data"},  32'(bus.wr_data),  32'd0);
    endtask

    // Random stream: 0..6 words, sometimes with a corrupted header/high byte
    // or (checksum build) a wrong checksum.
    task automatic buildRandom();
        int cnt;
        int corrupt;
        logic [8:0] ins;
        logic [7:0] hi;
        stream.delete();
        cnt     = $urandom_range(0, 6);
        corrupt = $urandom_range(0, 9);
        stream.push_back(8'(cnt));
        stream.push_back(corrupt == 0 ? 8'h04 : 8'h00);
        for (int i = 0; i < cnt; i++) begin
            ins = 9'($urandom);
            hi  = {7'd0, ins[8]};
            if (corrupt == 1 && i == cnt - 1) hi = hi | 8'h80;
            stream.push_back(ins[7:0]);
            stream.push_back(hi);
        end
        addCsum();
`ifdef PROG_LOADER_CHECKSUM_EN
        if (corrupt == 2) stream[stream.size() - 1] = stream[stream.size() - 1] ^ 8'h01;
`endif
    endtask

    // Main sequence.
    initial begin
        checkCount   = 0;
        errorCount   = 0;
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("reset");

        // Two-word back-to-back download with timing checks.
        stream = '{8'h02, 8'h00, 8'h0A, 8'h01, 8'hFF, 8'h00};
        addCsum();
        runStream("basic", 0);
        checkOutput("basic w0 const", 32'(obsWrites.size() > 0 ? obsWrites[0] : 19'h7FFFF), 32'({10'd0, 9'h10A}));
        checkOutput("basic w1 const", 32'(obsWrites.size() > 1 ? obsWrites[1] : 19'h7FFFF), 32'({10'd1, 9'h0FF}));
        if (obsWriteCyc.size() >= 2 && presentCyc.size() >= 6) begin
            checkOutput("basic w0 timing", 32'(obsWriteCyc[0]), 32'(presentCyc[3] + 1));
            checkOutput("basic w1 timing", 32'(obsWriteCyc[1]), 32'(presentCyc[5] + 1));
        end
        if (obsDoneCyc.size() >= 1 && presentCyc.size() >= 1) begin
            checkOutput("basic done timing", 32'(obsDoneCyc[0]), 32'(presentCyc[presentCyc.size() - 1] + 1));
            checkOutput("basic start at done", 32'(obsStartAtDone[0]), 32'd0);
        end

        // Zero-word program.
        stream = '{8'h00, 8'h00};
        addCsum();
        runStream("empty", 0);
        if (obsDoneCyc.size() >= 1 && presentCyc.size() >= 1)
            checkOutput("empty done timing", 32'(obsDoneCyc[0]), 32'(presentCyc[presentCyc.size() - 1] + 1));

        // High byte with reserved bits set.
        stream = '{8'h01, 8'h00, 8'h12, 8'h02};
        runStream("badhi", 0);

        // Three words with idle bubbles between bytes.
        stream = '{8'h03, 8'h00, 8'h31, 8'h01, 8'h42, 8'h00, 8'h53, 8'h01};
        addCsum();
        runStream("bubbles", 1);

        // Reset in the middle of a four-word download.
        stream = '{8'h04, 8'h00, 8'h11, 8'h01, 8'h22, 8'h00, 8'h33, 8'h01, 8'h44, 8'h00};
        clearObs();
        pulseLoad();
        for (int i = 0; i < 4; i++) applyStimulus(stream[i], 0);
        bus.in_valid = 1'b0;
        checkOutput("abort first write", 32'(bus.wr_en), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkAllZero("abort");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort no done", 32'(obsDoneCyc.size()), 32'd0);
        stream = '{8'h01, 8'h00, 8'h55, 8'h01};
        addCsum();
        runStream("reload", 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h04};
        runStream("csum good", 0);
        checkOutput("csum good done", 32'(obsDoneCyc.size()), 32'd1);
        stream = '{8'h01, 8'h00, 8'h05, 8'h00, 8'h05};
        runStream("csum bad", 0);
        checkOutput("csum bad error", 32'(bus.error), 32'd1);
`endif

        // Randomized streams with random bubbles.
        for (int t = 0; t < 40; t++) begin
            buildRandom();
            runStream($sformatf("rand%0d", t), 2);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
